// File: rtl/csa_resolver_pkg.sv
// Shared types and helpers for the iterative carry-save resolver.
package csa_resolver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int idx_width(input int num_chunks);
        if (num_chunks <= 1) begin
            return 1;
        end else begin
            return $clog2(num_chunks);
        end
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational WIDTH-bit ripple adder; bounds the per-cycle carry path.
module csa_chunk_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry_s;

    assign carry_s[0] = cin;
    assign cout       = carry_s[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the chunk ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into binary, CHUNK_WIDTH bits per cycle, with
// valid/ready handshakes on both sides.
module csa_resolver
    import csa_resolver_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] sum_in,
    input  logic [BIT_WIDTH-1:0] carry_in,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 cout,
    output logic                 busy
);

    localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [BIT_WIDTH-1:0]   a_r;
    logic [BIT_WIDTH-1:0]   b_r;
    logic                   carry_r;
    logic [IDX_W-1:0]       idx_r;
    logic [BIT_WIDTH-1:0]   result_r;
    logic                   cout_r;
    logic [CHUNK_WIDTH-1:0] chunk_sum_s;
    logic                   chunk_cout_s;
    logic                   last_s;

    assign last_s = (idx_r == IDX_W'(NUM_CHUNKS - 1));

    // Only the registered carry links one chunk to the next.
    csa_chunk_adder #(
        .WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a    (a_r[idx_r*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .b    (b_r[idx_r*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .cin  (carry_r),
        .sum  (chunk_sum_s),
        .cout (chunk_cout_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = ADD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture and chunk-by-chunk accumulation of the result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= sum_in;
                        b_r      <= carry_in;
                        carry_r  <= cin;
                        idx_r    <= '0;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                    end
                end
                ADD: begin
                    result_r[idx_r*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum_s;
                    carry_r <= chunk_cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        cout_r <= chunk_cout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign result    = result_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: vector table, scoreboard queue and
// hand-written backpressure / reset / full-width sequences.
module tb_csa_resolver;

    localparam int BW = 32;
    localparam int CW = 8;
    localparam int NC = BW / CW;

    typedef struct {
        logic [BW-1:0] s;
        logic [BW-1:0] c;
        logic          ci;
        logic [BW-1:0] er;
        logic          ec;
    } vec_t;

    typedef struct {
        logic [BW-1:0] r;
        logic          co;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [BW-1:0] sum_in, carry_in, result;
    logic          w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout, w_busy;
    logic [BW-1:0] w_sum_in, w_carry_in, w_result;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    csa_resolver #(.BIT_WIDTH(BW), .CHUNK_WIDTH(CW)) dut (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .carry_in(carry_in), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .busy(busy)
    );

    csa_resolver #(.BIT_WIDTH(BW), .CHUNK_WIDTH(BW)) dut_w (
        .CLK(clk), .RST(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .sum_in(w_sum_in), .carry_in(w_carry_in), .cin(w_cin),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .result(w_result), .cout(w_cout), .busy(w_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 33-bit addition.
    function automatic vec_t mk(input logic [BW-1:0] s, input logic [BW-1:0] c, input logic ci);
        vec_t  v;
        logic [BW:0] t;
        t    = {1'b0, s} + {1'b0, c} + {{BW{1'b0}}, ci};
        v.s  = s;
        v.c  = c;
        v.ci = ci;
        v.er = t[BW-1:0];
        v.ec = t[BW];
        return v;
    endfunction

    // Handshake one operand pair; returns at acceptance edge + 1.
    task automatic accept(input vec_t v);
        exp_t e;
        chk("in_ready_before_accept", in_ready, 1);
        sum_in   = v.s;
        carry_in = v.c;
        cin      = v.ci;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sum_in   = $urandom;
        carry_in = $urandom;
        cin      = ~v.ci;
        e.r  = v.er;
        e.co = v.ec;
        sb.push_back(e);
        chk("busy_in_add", busy, 1);
        chk("in_ready_in_add", in_ready, 0);
        chk("out_valid_in_add", out_valid, 0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_release", in_ready, 1);
        chk("out_valid_after_release", out_valid, 0);
    endtask

    task automatic await_result(input int lat, input bit do_release, output exp_t e);
        int k;
        k = 0;
        e.r  = '0;
        e.co = 1'b0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("out_valid_timeout", out_valid, 1);
        chk("latency", k, lat);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("cout", cout, e.co);
        end
        if (do_release) release_out();
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sum_in = '0; carry_in = '0; cin = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b0;
        w_sum_in = '0; w_carry_in = '0; w_cin = 1'b0;

        vecs[0] = '{32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1] = '{32'h1234_5678, 32'h1111_1110, 1'b0, 32'h2345_6788, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        for (int i = 4; i < 8; i++) begin
            vecs[i] = mk($urandom, $urandom, 1'($urandom));
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);

        for (int i = 0; i < 8; i++) begin
            accept(vecs[i]);
            await_result(NC, 1'b1, e);
        end

        // Backpressure: DONE must hold for as long as out_ready stays low.
        accept(vecs[1]);
        await_result(NC, 1'b0, e);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, e.r);
            chk("bp_cout", cout, e.co);
        end
        release_out();
        accept(vecs[0]);
        await_result(NC, 1'b1, e);

        // Reset after two ADD edges discards the operation.
        accept(vecs[0]);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_output", out_valid, 0);
        accept(vecs[2]);
        await_result(NC, 1'b1, e);

        // Single-chunk build: one cycle from acceptance to out_valid.
        chk("w_in_ready", w_in_ready, 1);
        w_sum_in   = 32'hFFFF_FFFE;
        w_carry_in = 32'h0000_0002;
        w_cin      = 1'b0;
        w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        w_sum_in   = '0;
        w_carry_in = '0;
        chk("w_busy", w_busy, 1);
        chk("w_out_valid_e0", w_out_valid, 0);
        @(posedge clk); #1;
        chk("w_out_valid_e1", w_out_valid, 1);
        chk("w_result", w_result, 0);
        chk("w_cout", w_cout, 1);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        chk("w_in_ready_after", w_in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
